// File: rtl/uart_rx_if.sv
// Byte-side handshake and status bundle of the UART receiver.
// The receiver drives through the master modport; the consumer uses slave.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: synchronises rx_i, rebuilds LSB-first frames with optional parity,
// and hands bytes to a valid/ready holding register with one-cycle error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rx_i,
  uart_rx_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 sync1_q, rx_s, prev_q;
  logic [2:0]           warm_q;
  logic                 fall, tick, stop_ok, stop_bad, accept;

  // warm_q delays edge detection until prev_q holds a genuinely sampled level,
  // so a line already low when reset releases is never taken as a start edge.
  assign fall = warm_q[2] & prev_q & ~rx_s;
  assign tick = (cnt_q == '0);

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked branch and only acts on an edge.
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      rx_s      <= 1'b1;
      prev_q    <= 1'b1;
      warm_q    <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      rx_s      <= sync1_q;
      prev_q    <= rx_s;
      warm_q    <= {warm_q[1:0], 1'b1};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    state_d   = state_q;
    cnt_d     = tick ? cnt_q : cnt_q - 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    unique case (state_q)
      S_IDLE: if (fall) begin
        state_d = S_START;
        cnt_d   = HALF_CNT;
      end
      S_START: if (tick) begin
        if (rx_s) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          cnt_d     = FULL_CNT;
          bit_idx_d = '0;
        end
      end
      S_DATA: if (tick) begin
        shift_d[bit_idx_q] = rx_s;
        cnt_d              = FULL_CNT;
        if (bit_idx_q == LAST_BIT) begin
          state_d   = PARITY_EN ? S_PARITY : S_STOP;
          par_bad_d = 1'b0;
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      S_PARITY: if (tick) begin
        par_bad_d = ((^shift_q) ^ rx_s) != PARITY_ODD;
        cnt_d     = FULL_CNT;
        state_d   = S_STOP;
      end
      S_STOP: if (tick) begin
        stop_ok  = rx_s;
        stop_bad = ~rx_s;
        state_d  = rx_s ? S_IDLE : S_BRK;
      end
      S_BRK: if (rx_s) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: a finished byte loads only if the slot is empty or being drained now.
  always_comb begin
    accept  = valid_q & bus.rx_ready;
    valid_d = valid_q & ~accept;
    data_d  = data_q;
    perr_d  = 1'b0;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;
    if (stop_ok) begin
      if (!valid_q || accept) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = PARITY_EN & par_bad_q;
      end else begin
        ovr_d = 1'b1;
      end
    end
    bus.busy       = (state_q != S_IDLE);
    bus.rx_data    = data_q;
    bus.rx_valid   = valid_q;
    bus.parity_err = perr_q;
    bus.frame_err  = ferr_q;
    bus.overrun    = ovr_q;
  end
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks/bit: a plain 8N1 receiver and an even-parity receiver,
// each with a byte scoreboard checked on every valid/ready transfer.
module tb_uart_rx;
  localparam int BIT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx = 1'b1;
  logic rx_p = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(8)) bus_if ();
  uart_rx_if #(.DATA_BITS(8)) bus_p ();

  uart_rx #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_i(rx), .bus(bus_if)
  );
  uart_rx #(.CLKS_PER_BIT(BIT), .DATA_BITS(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_p), .bus(bus_p)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_start_cyc = 0;
  int exp_q[$];
  int exp_p[$];

  int rise_cnt = 0, xfer_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, busy_rise = 0, rise_cyc = 0;
  int rise_p = 0, perr_p = 0, ferr_p = 0;
  logic prev_v = 1'b0, prev_b = 1'b0, prev_vp = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.rx_valid && !prev_v) begin
        rise_cnt++;
        rise_cyc = cyc;
      end
      if (bus_if.busy && !prev_b) busy_rise++;
      ferr_cnt += int'(bus_if.frame_err);
      perr_cnt += int'(bus_if.parity_err);
      ovr_cnt  += int'(bus_if.overrun);
      if (bus_if.rx_valid && bus_if.rx_ready) begin
        xfer_cnt++;
        check("rx_data", int'(bus_if.rx_data), (exp_q.size() != 0) ? exp_q.pop_front() : -1);
      end
    end
    prev_v = bus_if.rx_valid;
    prev_b = bus_if.busy;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_p.rx_valid && !prev_vp) rise_p++;
      ferr_p += int'(bus_p.frame_err);
      if (bus_p.parity_err) begin
        perr_p++;
        check("perr_with_delivery", int'(bus_p.rx_valid && !prev_vp), 1);
      end
      if (bus_p.rx_valid && bus_p.rx_ready)
        check("rx_data_par", int'(bus_p.rx_data), (exp_p.size() != 0) ? exp_p.pop_front() : -1);
    end
    prev_vp = bus_p.rx_valid;
  end

  // Called on a falling edge; sets the line and holds it for n cycles, ending on a falling edge.
  task automatic drive_level(input bit sel, input logic v, input int n);
    if (sel) rx_p = v;
    else     rx   = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit with_par,
                            input logic pbit, input logic stop_bit);
    last_start_cyc = cyc;
    drive_level(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) drive_level(sel, d[i], BIT);
    if (with_par) drive_level(sel, pbit, BIT);
    drive_level(sel, stop_bit, BIT);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 bus_if.rx_ready = v;
    @(negedge clk);
  endtask

  int base_rise, base_ferr, base_perr, base_ovr, base_busy;

  initial begin
    bus_if.rx_ready = 1'b1;
    bus_p.rx_ready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({bus_if.rx_valid, bus_if.busy, bus_if.parity_err,
                                 bus_if.frame_err, bus_if.overrun}), 0);
    check("reset_data", int'(bus_if.rx_data), 0);
    check("reset_outputs_par", int'({bus_p.rx_valid, bus_p.busy, bus_p.parity_err}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive_level(1'b0, 1'b1, 8);

    // 1: single 0x55, consumer always ready
    exp_q.push_back(8'h55);
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    drive_level(1'b0, 1'b1, 16);
    check("t1_valid_rises", rise_cnt, 1);
    check("t1_latency", rise_cyc - last_start_cyc, 155);
    check("t1_transfers", xfer_cnt, 1);
    check("t1_valid_dropped", int'(bus_if.rx_valid), 0);
    check("t1_no_flags", ferr_cnt + perr_cnt + ovr_cnt, 0);

    // 2: back-to-back frames while the consumer stalls
    set_ready(1'b0);
    exp_q.push_back(8'hA5);
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    drive_level(1'b0, 1'b1, 16);
    check("t2_overrun", ovr_cnt, 1);
    check("t2_held_valid", int'(bus_if.rx_valid), 1);
    check("t2_held_data", int'(bus_if.rx_data), 8'hA5);
    check("t2_valid_rises", rise_cnt, 2);
    set_ready(1'b1);
    drive_level(1'b0, 1'b1, 4);
    check("t2_valid_cleared", int'(bus_if.rx_valid), 0);
    check("t2_transfers", xfer_cnt, 2);

    // 3: short low glitch on an idle line
    base_rise = rise_cnt; base_ferr = ferr_cnt; base_busy = busy_rise;
    drive_level(1'b0, 1'b0, 6);
    drive_level(1'b0, 1'b1, 48);
    check("t3_no_valid", rise_cnt, base_rise);
    check("t3_no_frame_err", ferr_cnt, base_ferr);
    check("t3_busy_seen", busy_rise, base_busy + 1);
    check("t3_busy_idle", int'(bus_if.busy), 0);

    // 4: stop bit low followed by a long break, then a good frame
    base_rise = rise_cnt;
    send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    drive_level(1'b0, 1'b0, 40 * BIT);
    drive_level(1'b0, 1'b1, 32);
    check("t4_frame_err_once", ferr_cnt, 1);
    check("t4_no_valid", rise_cnt, base_rise);
    check("t4_no_parity_err", perr_cnt, 0);
    exp_q.push_back(8'h12);
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    drive_level(1'b0, 1'b1, 16);
    check("t4_recovered", rise_cnt, base_rise + 1);

    // 5: even parity receiver, good then bad parity bit
    exp_p.push_back(8'h07);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    drive_level(1'b1, 1'b1, 16);
    check("t5_good_no_perr", perr_p, 0);
    exp_p.push_back(8'h07);
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    drive_level(1'b1, 1'b1, 16);
    check("t5_bad_perr", perr_p, 1);
    check("t5_deliveries", rise_p, 2);
    check("t5_no_frame_err", ferr_p, 0);

    // 6: reset pulse in the middle of bit 4 of 0x81
    base_rise = rise_cnt; base_ferr = ferr_cnt; base_perr = perr_cnt; base_ovr = ovr_cnt;
    drive_level(1'b0, 1'b0, BIT);
    drive_level(1'b0, 1'b1, BIT);
    drive_level(1'b0, 1'b0, 3 * BIT + 8);
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_reset_outputs", int'({bus_if.rx_valid, bus_if.busy, bus_if.parity_err,
                                    bus_if.frame_err, bus_if.overrun}), 0);
    check("t6_reset_data", int'(bus_if.rx_data), 0);
    rst_n = 1'b1;
    @(negedge clk);
    drive_level(1'b0, 1'b0, 40);
    drive_level(1'b0, 1'b1, 2 * BIT + 32);
    check("t6_no_false_frame", rise_cnt, base_rise);
    check("t6_no_flags", (ferr_cnt - base_ferr) + (perr_cnt - base_perr) + (ovr_cnt - base_ovr), 0);
    check("t6_idle", int'(bus_if.busy), 0);
    exp_q.push_back(8'h81);
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    drive_level(1'b0, 1'b1, 16);
    check("t6_clean_frame", rise_cnt, base_rise + 1);

    check("sb_drained", exp_q.size(), 0);
    check("sb_drained_par", exp_p.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
